// File: rtl/md_pkg.sv
// ---------------------------------------------------------------------------
// md_pkg: shared multiply/divide op encodings, latencies and FSM states. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;

  localparam logic [3:0] MD_MULT_LAT = 4'd5;
  localparam logic [3:0] MD_DIV_LAT  = 4'd10;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } md_state_t;

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/md_arith.sv
// ---------------------------------------------------------------------------
// md_arith: combinational 64-bit multiply / 32-bit divide datapath. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  way,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo
);

  logic signed [63:0] sprod;
  logic        [63:0] uprod;
  logic        [31:0] b_nz;
  logic        [31:0] squo;
  logic        [31:0] srem;
  logic               sovf;

  // Divisor forced non-zero so the divider never sees 0; the zero case is muxed below.
  assign b_nz  = (b == '0) ? 32'd1 : b;
  // -2^31 / -1 overflows a 32-bit signed divide; its wrapped result is fixed here.
  assign sovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
  assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign uprod = {32'd0, a} * {32'd0, b};
  assign squo  = sovf ? 32'h8000_0000 : $unsigned($signed(a) / $signed(b_nz));
  assign srem  = sovf ? 32'd0         : $unsigned($signed(a) % $signed(b_nz));

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (way)
      MD_MULT:  {res_hi, res_lo} = sprod;
      MD_MULTU: {res_hi, res_lo} = uprod;
      MD_DIV: begin
        if (b == '0) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = srem;
          res_lo = squo;
        end
      end
      MD_DIVU: begin
        if (b == '0) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = a % b_nz;
          res_lo = a / b_nz;
        end
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/md_ctrl.sv
// ---------------------------------------------------------------------------
// md_ctrl: multi-cycle mult/div controller with HI/LO; MD_DIV0_FAST_EN enables 1-cycle divide-by-zero. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module md_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        eret,
  input  logic        start,
  input  logic [2:0]  way,
  input  logic [31:0] w1,
  input  logic [31:0] w2,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        d_md,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state;
  md_state_t   state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [3:0]  lat;
  logic [2:0]  way_q;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        accept;
  logic        commit;
  logic        commit_wr;
  logic        mv_ok;

  assign accept   = (state == IDLE) && start && !req && (way <= MD_DIVU);
  assign commit   = (state == RUN) && (cnt == 4'd1);
  // mthi/mtlo only land in an idle cycle that is not flushed and not taken by a launch.
  assign mv_ok    = (state == IDLE) && !req && !eret && !accept;
  assign busy     = (state == RUN);
  assign md_stall = (start | busy) & d_md;

`ifdef MD_DIV0_FAST_EN
  always_comb begin
    lat = md_is_div(way) ? MD_DIV_LAT : MD_MULT_LAT;
    if (md_is_div(way) && (w2 == '0)) lat = 4'd1;
  end
  assign commit_wr = commit && !(md_is_div(way_q) && (op_b == '0));
`else
  always_comb begin
    lat = md_is_div(way) ? MD_DIV_LAT : MD_MULT_LAT;
  end
  assign commit_wr = commit;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nx = RUN;
          cnt_nx   = lat;
        end
      end
      RUN: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      way_q <= '0;
      op_a  <= '0;
      op_b  <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        way_q <= way;
        op_a  <= w1;
        op_b  <= w2;
      end
      if (commit_wr) begin
        hi <= res_hi;
        lo <= res_lo;
      end else begin
        if (hi_we && mv_ok) hi <= w1;
        if (lo_we && mv_ok) lo <= w1;
      end
    end
  end

  md_arith u_arith (
    .way    (way_q),
    .a      (op_a),
    .b      (op_b),
    .res_hi (res_hi),
    .res_lo (res_lo)
  );

endmodule

`default_nettype wire
